// File: rtl/ipsxe_floating_point_fl2fl_widen_v1_0.sv
// ipsxe_floating_point_fl2fl_widen_v1_0
// Exact widening float-to-float converter (default single -> double) behind an
// AXI4-Stream style valid/ready pipeline of 1 or 2 stages.
// Every input value is exactly representable in the output format. As a result there is
// no rounding, overflow or underflow. Input subnormals are renormalised using a
// leading-zero count. NaNs always come out quiet, with their payload left-aligned.
//
// Ports:
//   i_aclk, i_areset_n      clock, asynchronous active-low reset
//   i_aclken                clock enable; low freezes every register and drops tready
//   i_axi4s_a_tdata/tvalid  input operand {sign, exp, frac}
//   o_axi4s_a_tready        input ready (combinational through the stage chain)
//   o_axi4s_result_*        converted result stream
//   o_invalid_op            signaling-NaN flag travelling with the result beat
//
// Optional build macro IPSXE_FL2FL_WIDEN_SNAN_FLAG_EN enables the o_invalid_op
// pipeline. When it is undefined, the flag is tied to zero.
module ipsxe_floating_point_fl2fl_widen_v1_0 #(
  parameter int FLOAT_IN_EXP   = 8,
  parameter int FLOAT_IN_FRAC  = 24,
  parameter int FLOAT_OUT_EXP  = 11,
  parameter int FLOAT_OUT_FRAC = 53,
  parameter int LATENCY_CONFIG = 2
) (
  input  logic                                    i_aclk,
  input  logic                                    i_areset_n,
  input  logic                                    i_aclken,
  input  logic [FLOAT_IN_EXP+FLOAT_IN_FRAC-1:0]   i_axi4s_a_tdata,
  input  logic                                    i_axi4s_a_tvalid,
  output logic                                    o_axi4s_a_tready,
  output logic [FLOAT_OUT_EXP+FLOAT_OUT_FRAC-1:0] o_axi4s_result_tdata,
  output logic                                    o_axi4s_result_tvalid,
  input  logic                                    i_axi4s_result_tready,
  output logic                                    o_invalid_op
);

  localparam int IE  = FLOAT_IN_EXP;
  localparam int OE  = FLOAT_OUT_EXP;
  localparam int FI  = FLOAT_IN_FRAC - 1;
  localparam int FO  = FLOAT_OUT_FRAC - 1;
  localparam int BI  = (1 << (IE - 1)) - 1;
  localparam int BO  = (1 << (OE - 1)) - 1;
  localparam int IW  = IE + FLOAT_IN_FRAC;
  localparam int OW  = OE + FLOAT_OUT_FRAC;
  localparam int PAD = FO - FI;
  localparam int LZW = $clog2(FI + 1);
  // Rebias offset; also the exponent of a subnormal whose leading one is frac MSB.
  localparam logic [OE-1:0] EXP_ADJ = OE'(BO - BI);

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_NAN  = 3'd4
  } cls_t;

  // Count the leading zeros of a fraction field. The highest set bit wins.
  function automatic logic [LZW-1:0] lzc(input logic [FI-1:0] f);
    logic [LZW-1:0] n;
    n = {LZW{1'b0}};
    for (int i = 0; i < FI; i++) begin
      if (f[i]) n = LZW'(FI - 1 - i);
    end
    return n;
  endfunction

  function automatic cls_t classify(input logic [IE-1:0] e, input logic [FI-1:0] f);
    cls_t c;
    if (e == {IE{1'b0}}) begin
      c = (f == {FI{1'b0}}) ? CLS_ZERO : CLS_SUB;
    end else if (e == {IE{1'b1}}) begin
      c = (f == {FI{1'b0}}) ? CLS_INF : CLS_NAN;
    end else begin
      c = CLS_NORM;
    end
    return c;
  endfunction

  function automatic logic [OW-1:0] encode(input logic s, input cls_t c,
                                           input logic [IE-1:0] e_in,
                                           input logic [FI-1:0] f_in,
                                           input logic [LZW-1:0] lz);
    logic [OE-1:0] e;
    logic [FO-1:0] f;
    logic [FI-1:0] sh;
    sh = f_in << (int'(lz) + 1);  // drops the leading one of a subnormal
    case (c)
      CLS_ZERO: begin e = {OE{1'b0}}; f = {FO{1'b0}}; end
      CLS_INF:  begin e = {OE{1'b1}}; f = {FO{1'b0}}; end
      CLS_NORM: begin e = EXP_ADJ + OE'(e_in); f = FO'(f_in) << PAD; end
      CLS_SUB:  begin e = EXP_ADJ - OE'(lz);   f = FO'(sh) << PAD;   end
      CLS_NAN:  begin
        e = {OE{1'b1}};
        f = FO'(f_in) << PAD;
        f[FO-1] = 1'b1;  // quiet bit forced, lower payload kept left-aligned
      end
      default:  begin e = {OE{1'b0}}; f = {FO{1'b0}}; end
    endcase
    return {s, e, f};
  endfunction

  // Input-side decode shared by both pipeline depths.
  logic             in_sign_s;
  logic [IE-1:0]    in_exp_s;
  logic [FI-1:0]    in_frac_s;
  cls_t             in_cls_s;
  logic [LZW-1:0]   in_lz_s;

  assign in_sign_s = i_axi4s_a_tdata[IW-1];
  assign in_exp_s  = i_axi4s_a_tdata[IW-2 -: IE];
  assign in_frac_s = i_axi4s_a_tdata[FI-1:0];
  assign in_cls_s  = classify(in_exp_s, in_frac_s);
  assign in_lz_s   = lzc(in_frac_s);

  logic             result_valid_r;
  logic [OW-1:0]    result_data_r;

  assign o_axi4s_result_tvalid = result_valid_r;
  assign o_axi4s_result_tdata  = result_data_r;

`ifdef IPSXE_FL2FL_WIDEN_SNAN_FLAG_EN
  logic in_snan_s;
  logic invalid_r;
  assign in_snan_s    = (in_cls_s == CLS_NAN) & ~in_frac_s[FI-1];
  assign o_invalid_op = invalid_r;
`else
  assign o_invalid_op = 1'b0;
`endif

  generate
    if (LATENCY_CONFIG == 1) begin : g_lat1
      logic ready_out_s;
      assign ready_out_s      = ~result_valid_r | i_axi4s_result_tready;
      assign o_axi4s_a_tready = i_aclken & ready_out_s;

      // Single stage: classify, normalise and encode straight into the output register.
      always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
          result_valid_r <= 1'b0;
          result_data_r  <= {OW{1'b0}};
`ifdef IPSXE_FL2FL_WIDEN_SNAN_FLAG_EN
          invalid_r      <= 1'b0;
`endif
        end else if (i_aclken && ready_out_s) begin
          result_valid_r <= i_axi4s_a_tvalid;
          if (i_axi4s_a_tvalid) begin
            result_data_r <= encode(in_sign_s, in_cls_s, in_exp_s, in_frac_s, in_lz_s);
`ifdef IPSXE_FL2FL_WIDEN_SNAN_FLAG_EN
            invalid_r     <= in_snan_s;
`endif
          end
        end
      end
    end else begin : g_lat2
      logic           s1_valid_r;
      logic           s1_sign_r;
      cls_t           s1_cls_r;
      logic [IE-1:0]  s1_exp_r;
      logic [FI-1:0]  s1_frac_r;
      logic [LZW-1:0] s1_lz_r;
      logic           ready_1_s;
      logic           ready_2_s;
`ifdef IPSXE_FL2FL_WIDEN_SNAN_FLAG_EN
      logic           s1_snan_r;
`endif

      assign ready_2_s        = ~result_valid_r | i_axi4s_result_tready;
      assign ready_1_s        = ~s1_valid_r | ready_2_s;
      assign o_axi4s_a_tready = i_aclken & ready_1_s;

      // Stage 1 register: classification and leading-zero count.
      always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
          s1_valid_r <= 1'b0;
          s1_sign_r  <= 1'b0;
          s1_cls_r   <= CLS_ZERO;
          s1_exp_r   <= {IE{1'b0}};
          s1_frac_r  <= {FI{1'b0}};
          s1_lz_r    <= {LZW{1'b0}};
`ifdef IPSXE_FL2FL_WIDEN_SNAN_FLAG_EN
          s1_snan_r  <= 1'b0;
`endif
        end else if (i_aclken && ready_1_s) begin
          s1_valid_r <= i_axi4s_a_tvalid;
          if (i_axi4s_a_tvalid) begin
            s1_sign_r <= in_sign_s;
            s1_cls_r  <= in_cls_s;
            s1_exp_r  <= in_exp_s;
            s1_frac_r <= in_frac_s;
            s1_lz_r   <= in_lz_s;
`ifdef IPSXE_FL2FL_WIDEN_SNAN_FLAG_EN
            s1_snan_r <= in_snan_s;
`endif
          end
        end
      end

      // Stage 2 register: shift, rebias and pack the result.
      always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
          result_valid_r <= 1'b0;
          result_data_r  <= {OW{1'b0}};
`ifdef IPSXE_FL2FL_WIDEN_SNAN_FLAG_EN
          invalid_r      <= 1'b0;
`endif
        end else if (i_aclken && ready_2_s) begin
          result_valid_r <= s1_valid_r;
          if (s1_valid_r) begin
            result_data_r <= encode(s1_sign_r, s1_cls_r, s1_exp_r, s1_frac_r, s1_lz_r);
`ifdef IPSXE_FL2FL_WIDEN_SNAN_FLAG_EN
            invalid_r     <= s1_snan_r;
`endif
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ipsxe_floating_point_fl2fl_widen_v1_0.sv
// Directed testbench for ipsxe_floating_point_fl2fl_widen_v1_0 (default single -> double, 2 stages).
module tb_ipsxe_floating_point_fl2fl_widen_v1_0;

  localparam int LAT = 2;
  localparam int NV  = 12;

`ifdef IPSXE_FL2FL_WIDEN_SNAN_FLAG_EN
  localparam logic SNAN_FLAG = 1'b1;
`else
  localparam logic SNAN_FLAG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aclken;
  logic [31:0] a_tdata;
  logic        a_tvalid;
  logic        a_tready;
  logic [63:0] r_tdata;
  logic        r_tvalid;
  logic        r_tready;
  logic        invalid_op;

  int checks = 0;
  int errors = 0;

  logic [31:0] vin  [NV];
  logic [63:0] vout [NV];
  logic        vinv [NV];

  ipsxe_floating_point_fl2fl_widen_v1_0 dut (
    .i_aclk                (clk),
    .i_areset_n            (rst_n),
    .i_aclken              (aclken),
    .i_axi4s_a_tdata       (a_tdata),
    .i_axi4s_a_tvalid      (a_tvalid),
    .o_axi4s_a_tready      (a_tready),
    .o_axi4s_result_tdata  (r_tdata),
    .o_axi4s_result_tvalid (r_tvalid),
    .i_axi4s_result_tready (r_tready),
    .o_invalid_op          (invalid_op)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; aclken = 1'b1; a_tvalid = 1'b0; a_tdata = 32'h0; r_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (r_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", r_tvalid); end
    checks++; if (r_tdata !== 64'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", r_tdata); end
    checks++; if (invalid_op !== 1'b0) begin errors++; $display("FAIL reset_invalid got %b want 0", invalid_op); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got %b want 1", a_tready); end
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (r_tvalid !== 1'b0) begin errors++; $display("FAIL idle_tvalid got %b want 0", r_tvalid); end
    end
  endtask

  task automatic test_directed();
    int cyc;
    for (int k = 0; k < NV; k++) begin
      a_tdata = vin[k]; a_tvalid = 1'b1; r_tready = 1'b1;
      #1;
      checks++; if (a_tready !== 1'b1) begin errors++; $display("FAIL dir_tready[%0d] got %b want 1", k, a_tready); end
      @(posedge clk); #1;
      a_tvalid = 1'b0;
      cyc = 1;
      while (r_tvalid !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
      checks++; if (cyc != LAT) begin errors++; $display("FAIL dir_latency[%0d] got %0d want %0d", k, cyc, LAT); end
      checks++; if (r_tdata !== vout[k]) begin errors++; $display("FAIL dir_data[%0d] in %h got %h want %h", k, vin[k], r_tdata, vout[k]); end
      checks++; if (invalid_op !== vinv[k]) begin errors++; $display("FAIL dir_invalid[%0d] got %b want %b", k, invalid_op, vinv[k]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int sent, got;
    logic [63:0] prev_d;
    logic held;
    logic exp_rdy;
    sent = 0; got = 0; held = 1'b0; prev_d = 64'h0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      r_tready = (cyc >= 5);
      a_tvalid = (sent < 6);
      a_tdata  = vin[sent % 6];
      #1;
      exp_rdy = !(cyc >= 2 && cyc < 5);
      checks++; if (a_tready !== exp_rdy) begin errors++; $display("FAIL bp_tready cyc %0d got %b want %b", cyc, a_tready, exp_rdy); end
      if (held) begin
        checks++; if (r_tdata !== prev_d) begin errors++; $display("FAIL bp_held cyc %0d got %h want %h", cyc, r_tdata, prev_d); end
      end
      if (cyc >= 5) begin
        checks++; if (r_tvalid !== 1'b1) begin errors++; $display("FAIL bp_drain_gap cyc %0d got %b want 1", cyc, r_tvalid); end
      end
      if (r_tvalid && r_tready) begin
        checks++; if (r_tdata !== vout[got]) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", got, r_tdata, vout[got]); end
        got++;
      end
      if (a_tvalid && a_tready) sent++;
      held = r_tvalid && !r_tready;
      prev_d = r_tdata;
      @(posedge clk); #1;
    end
    a_tvalid = 1'b0;
    checks++; if (got != 6) begin errors++; $display("FAIL bp_count got %0d want 6", got); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_aclken();
    int sent, got;
    logic [63:0] prev_d;
    logic prev_v, frozen;
    sent = 0; got = 0; frozen = 1'b0; prev_d = 64'h0; prev_v = 1'b0;
    r_tready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      aclken   = !(cyc == 2 || cyc == 3);
      a_tvalid = (sent < 4);
      a_tdata  = vin[6 + (sent % 4)];
      #1;
      if (!aclken) begin
        checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL ce_tready cyc %0d got %b want 0", cyc, a_tready); end
      end
      if (frozen) begin
        checks++;
        if (r_tvalid !== prev_v || r_tdata !== prev_d) begin
          errors++; $display("FAIL ce_hold cyc %0d got %b/%h want %b/%h", cyc, r_tvalid, r_tdata, prev_v, prev_d);
        end
      end
      if (r_tvalid && r_tready && aclken) begin
        checks++; if (r_tdata !== vout[6 + got] || invalid_op !== vinv[6 + got]) begin
          errors++; $display("FAIL ce_data[%0d] got %h/%b want %h/%b", got, r_tdata, invalid_op, vout[6 + got], vinv[6 + got]);
        end
        got++;
      end
      if (a_tvalid && a_tready) sent++;
      frozen = !aclken;
      prev_v = r_tvalid; prev_d = r_tdata;
      @(posedge clk); #1;
    end
    a_tvalid = 1'b0; aclken = 1'b1;
    checks++; if (got != 4) begin errors++; $display("FAIL ce_count got %0d want 4", got); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_inflight();
    int cyc;
    aclken = 1'b1; r_tready = 1'b0;
    a_tvalid = 1'b1; a_tdata = vin[0];
    @(posedge clk); #1;
    a_tdata = vin[6];
    @(posedge clk); #1;
    a_tvalid = 1'b0;
    checks++; if (r_tvalid !== 1'b1) begin errors++; $display("FAIL rst_inflight_pre got %b want 1", r_tvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (r_tvalid !== 1'b0) begin errors++; $display("FAIL rst_async_tvalid got %b want 0", r_tvalid); end
    checks++; if (r_tdata !== 64'h0) begin errors++; $display("FAIL rst_async_tdata got %h want 0", r_tdata); end
    checks++; if (invalid_op !== 1'b0) begin errors++; $display("FAIL rst_async_invalid got %b want 0", invalid_op); end
    @(posedge clk); #1;
    rst_n = 1'b1; r_tready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checks++; if (r_tvalid !== 1'b0) begin errors++; $display("FAIL rst_ghost got %b want 0", r_tvalid); end
    end
    a_tvalid = 1'b1; a_tdata = vin[2];
    @(posedge clk); #1;
    a_tvalid = 1'b0;
    cyc = 1;
    while (r_tvalid !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc != LAT || r_tdata !== vout[2]) begin
      errors++; $display("FAIL rst_resume got lat %0d data %h want lat %0d data %h", cyc, r_tdata, LAT, vout[2]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vin[0]  = 32'h3F800000; vout[0]  = 64'h3FF0000000000000; vinv[0]  = 1'b0;
    vin[1]  = 32'h00000001; vout[1]  = 64'h36A0000000000000; vinv[1]  = 1'b0;
    vin[2]  = 32'h00400000; vout[2]  = 64'h3800000000000000; vinv[2]  = 1'b0;
    vin[3]  = 32'h80000000; vout[3]  = 64'h8000000000000000; vinv[3]  = 1'b0;
    vin[4]  = 32'hFF800000; vout[4]  = 64'hFFF0000000000000; vinv[4]  = 1'b0;
    vin[5]  = 32'hC0200000; vout[5]  = 64'hC004000000000000; vinv[5]  = 1'b0;
    vin[6]  = 32'h7F800001; vout[6]  = 64'h7FF8000020000000; vinv[6]  = SNAN_FLAG;
    vin[7]  = 32'h7FC00000; vout[7]  = 64'h7FF8000000000000; vinv[7]  = 1'b0;
    vin[8]  = 32'h7F7FFFFF; vout[8]  = 64'h47EFFFFFE0000000; vinv[8]  = 1'b0;
    vin[9]  = 32'h00800000; vout[9]  = 64'h3810000000000000; vinv[9]  = 1'b0;
    vin[10] = 32'h007FFFFF; vout[10] = 64'h380FFFFFC0000000; vinv[10] = 1'b0;
    vin[11] = 32'hFFC00001; vout[11] = 64'hFFF8000020000000; vinv[11] = 1'b0;

    test_reset();
    test_directed();
    test_backpressure();
    test_aclken();
    test_reset_inflight();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
